ref_row_streamer: RTL and testbench

Feeds the subpixel interpolation datapath with reference pixel rows. It reads a 15×15 block of 8-bit luma pixels from a synchronous frame-store RAM, two 64-bit words per row. It assembles each row into a 120-bit word and hands rows to the interpolator over a valid/ready link through a 2-entry row FIFO. It is the producer for the interpolator's 120-bit `in_row` input and sits between the frame store and the interpolation top level.

---
 rtl/ref_row_streamer.sv | 164 ++++++++++++++++
 tb/tb_ref_row_streamer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ref_row_streamer.sv
// Reference row streamer: fetches a 15-row block from the frame store (two
// 64-bit reads per row) and hands 120-bit rows to the interpolator through a 2-entry FIFO.
module ref_row_streamer #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned NUM_ROWS = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rd_data,
    output logic [119:0]      row_out,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [3:0]        row_idx
);

    localparam int unsigned ROW_W  = 120;
    localparam int unsigned WORD_W = 64;
    localparam int unsigned HI_W   = ROW_W - WORD_W;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {IDLE, FETCH_LO, FETCH_HI, PUSH, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       row_addr_q, row_addr_d;
    logic [ADDR_W-1:0]       stride_q, stride_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]       row_lo_q, row_lo_d;
    logic [CNT_W-1:0]        rows_q, rows_d;
    logic [CNT_W-1:0]        pops_q, pops_d;
    logic [1:0][ROW_W-1:0]   fifo_q, fifo_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_en_q, rd_en_d;
    logic                    push, pop;
    logic                    unused_pix15;

    // Pixel 15 of the high word has no slot in the 15-pixel row.
    assign unused_pix15 = ^mem_rd_data[63:56];

    assign push = (state_q == PUSH);
    assign pop  = (count_q != 2'd0) && row_ready;

    // Next-state, FIFO bookkeeping and registered-output decode.
    always_comb begin
        state_d    = state_q;
        row_addr_d = row_addr_q;
        stride_d   = stride_q;
        mem_addr_d = mem_addr_q;
        row_lo_d   = row_lo_q;
        rows_d     = rows_q;
        pops_d     = pops_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        done_d     = 1'b0;

        count_d = count_q + 2'(push) - 2'(pop);
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            pops_d   = pops_q + 4'd1;
        end
        if (push) begin
            fifo_d[wr_ptr_q] = {mem_rd_data[HI_W-1:0], row_lo_q};
            wr_ptr_d         = ~wr_ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    row_addr_d = base_addr;
                    stride_d   = stride;
                    rows_d     = '0;
                    pops_d     = '0;
                    state_d    = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (rd_en_q) state_d = FETCH_HI;
            end
            FETCH_HI: begin
                row_lo_d   = mem_rd_data;
                row_addr_d = row_addr_q + stride_q;
                state_d    = PUSH;
            end
            PUSH: begin
                rows_d  = rows_q + 4'd1;
                state_d = (rows_q == CNT_W'(NUM_ROWS - 1)) ? DRAIN : FETCH_LO;
            end
            DRAIN: begin
                if (count_d == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The low-word read is only issued once a FIFO slot is guaranteed free.
        rd_en_d = ((state_d == FETCH_LO) && (count_d != 2'd2)) || (state_d == FETCH_HI);
        if (state_d == FETCH_LO) mem_addr_d = row_addr_d;
        else if (state_d == FETCH_HI) mem_addr_d = row_addr_q + ADDR_W'(1);

        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_addr_q <= '0;
            stride_q   <= '0;
            mem_addr_q <= '0;
            row_lo_q   <= '0;
            rows_q     <= '0;
            pops_q     <= '0;
            fifo_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_addr_q <= row_addr_d;
            stride_q   <= stride_d;
            mem_addr_q <= mem_addr_d;
            row_lo_q   <= row_lo_d;
            rows_q     <= rows_d;
            pops_q     <= pops_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (count_q != 2'd2) else $error("row fifo overflow on push");
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign row_out   = fifo_q[rd_ptr_q];
    assign row_valid = (count_q != 2'd0);
    assign row_idx   = pops_q;

endmodule

// File: tb/tb_ref_row_streamer.sv
// Directed bench for ref_row_streamer: RAM model plus a row scoreboard filled at start.
module tb_ref_row_streamer;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned NUM_ROWS = 15;

    logic              clk = 1'b0;
    logic              rst, start, busy, done, mem_rd_en, row_valid, row_ready;
    logic [ADDR_W-1:0] base_addr, stride, mem_addr;
    logic [63:0]       mem_rd_data;
    logic [119:0]      row_out;
    logic [3:0]        row_idx;

    typedef struct packed {
        logic [119:0] row;
        logic [3:0]   idx;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   rel   = 0;
    int   rd_cnt = 0;
    int   rd0   = 0;
    logic aa_mode = 1'b0;

    always #5 clk = ~clk;

    ref_row_streamer #(.ADDR_W(ADDR_W), .NUM_ROWS(NUM_ROWS)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .row_out(row_out), .row_valid(row_valid),
        .row_ready(row_ready), .row_idx(row_idx)
    );

    function automatic logic [63:0] ramw(input logic [15:0] a);
        logic [63:0] w;
        w = {8{a[7:0]}};
        if (aa_mode && a[0]) w[63:56] = 8'hAA;
        return w;
    endfunction

    // Synchronous RAM: data only meaningful the cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= ramw(mem_addr);
            rd_cnt      <= rd_cnt + 1;
        end else begin
            mem_rd_data <= {$urandom, $urandom};
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; pops seen at the falling edge are scored.
    task automatic tick();
        exp_t e;
        logic found;
        @(negedge clk);
        if (row_valid === 1'b1 && row_ready === 1'b1) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_row: observed idx %0d expected no row", row_idx);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("row_data", 128'(row_out), 128'(e.row));
                chk("row_idx", 128'(row_idx), 128'(e.idx));
            end
            if (aa_mode) begin
                found = 1'b0;
                for (int k = 0; k < 15; k++) if (row_out[8*k +: 8] == 8'hAA) found = 1'b1;
                chk("pix15_dropped", 128'(found), 128'(0));
            end
        end
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic step_to(input int n);
        while (rel < n) tick();
    endtask

    task automatic start_blk(input logic [15:0] b, input logic [15:0] s);
        logic [15:0] a;
        exp_t e;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            a     = b + 16'(r) * s;
            e.row = {ramw(a + 16'd1) & 64'h00FF_FFFF_FFFF_FFFF, ramw(a)}[119:0];
            e.idx = 4'(r);
            sb.push_back(e);
        end
        base_addr = b;
        stride    = s;
        start     = 1'b1;
        rel       = 0;
        rd0       = rd_cnt;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 80) begin
            tick();
            guard++;
        end
        chk({tag, "_done_seen"}, 128'(done), 128'(1));
        if (exp_cyc >= 0) chk({tag, "_done_cycle"}, 128'(rel), 128'(exp_cyc));
        tick();
        chk({tag, "_busy_low"}, 128'(busy), 128'(0));
        chk({tag, "_all_rows"}, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; row_ready = 1'b1;
        base_addr = '0; stride = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_rd_en", 128'(mem_rd_en), 128'(0));
        chk("rst_addr", 128'(mem_addr), 128'(0));
        chk("rst_valid", 128'(row_valid), 128'(0));
        chk("rst_row", 128'(row_out), 128'(0));
        chk("rst_idx", 128'(row_idx), 128'(0));
        tick();

        // Basic stream with exact cycle timing
        start_blk(16'h0100, 16'h0010);
        chk("t1_busy_c1", 128'(busy), 128'(1));
        chk("t1_rd_en_c1", 128'(mem_rd_en), 128'(1));
        chk("t1_addr_c1", 128'(mem_addr), 128'(16'h0100));
        tick();
        chk("t1_rd_en_c2", 128'(mem_rd_en), 128'(1));
        chk("t1_addr_c2", 128'(mem_addr), 128'(16'h0101));
        tick();
        chk("t1_rd_en_c3", 128'(mem_rd_en), 128'(0));
        chk("t1_valid_c3", 128'(row_valid), 128'(0));
        tick();
        chk("t1_valid_c4", 128'(row_valid), 128'(1));
        wait_done("t1", 47);
        tick();

        // Backpressure: ready low through cycle 30
        row_ready = 1'b0;
        start_blk(16'h0100, 16'h0010);
        while (rel < 30) begin
            tick();
            if (rel >= 6) chk("t2_rd_stall", 128'(mem_rd_en), 128'(0));
        end
        chk("t2_reads_issued", 128'(rd_cnt - rd0), 128'(4));
        chk("t2_valid_held", 128'(row_valid), 128'(1));
        chk("t2_idx_held", 128'(row_idx), 128'(0));
        tick();
        row_ready = 1'b1;
        chk("t2_rd_en_c31", 128'(mem_rd_en), 128'(0));
        tick();
        chk("t2_resume_c32", 128'(mem_rd_en), 128'(1));
        wait_done("t2", -1);
        tick();

        // Address wrap
        start_blk(16'hFFFF, 16'h0010);
        chk("t3_addr_r0_lo", 128'(mem_addr), 128'(16'hFFFF));
        tick();
        chk("t3_addr_r0_hi", 128'(mem_addr), 128'(16'h0000));
        step_to(4);
        chk("t3_rd_en_r1", 128'(mem_rd_en), 128'(1));
        chk("t3_addr_r1_lo", 128'(mem_addr), 128'(16'h000F));
        tick();
        chk("t3_addr_r1_hi", 128'(mem_addr), 128'(16'h0010));
        wait_done("t3", 47);
        tick();

        // Pixel 15 drop
        aa_mode = 1'b1;
        start_blk(16'h0100, 16'h0010);
        wait_done("t4", 47);
        aa_mode = 1'b0;
        tick();

        // Start while busy (cycle 10 and cycle 46) is ignored
        start_blk(16'h0200, 16'h0020);
        step_to(10);
        base_addr = 16'h0700; start = 1'b1;
        tick();
        start = 1'b0;
        step_to(46);
        base_addr = 16'h0900; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t5", 47);
        tick();
        chk("t5_no_restart", 128'(busy), 128'(0));

        // Reset mid-block with one row buffered
        row_ready = 1'b0;
        start_blk(16'h0100, 16'h0010);
        step_to(18);
        row_ready = 1'b1;
        tick();
        row_ready = 1'b0;
        step_to(20);
        chk("t6_one_buffered", 128'(row_valid), 128'(1));
        rst = 1'b1;
        tick();
        sb.delete();
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_done", 128'(done), 128'(0));
        chk("t6_rd_en", 128'(mem_rd_en), 128'(0));
        chk("t6_addr", 128'(mem_addr), 128'(0));
        chk("t6_valid", 128'(row_valid), 128'(0));
        chk("t6_row", 128'(row_out), 128'(0));
        chk("t6_idx", 128'(row_idx), 128'(0));
        rst = 1'b0;
        tick();
        row_ready = 1'b1;
        start_blk(16'h0300, 16'h0040);
        wait_done("t6", 47);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
